// File: rtl/trng_pkg.sv
// Shared constants and helpers for the TRNG post-processing path.
package trng_pkg;

  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_VN  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through FIFO; head visible the cycle after the push, 0 when empty.
// Backpressure: caller gates pushes on full, except a push may ride alongside a pop.
module trng_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // a pop frees the slot in the same edge, so a push into a full FIFO is still legal then
  assign do_push = push & (~full | do_pop);
  assign pop_dat = empty ? '0 : mem[rptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/trng_collector.sv
// XOR-combine, repetition-count health test, optional von Neumann debias, pack, FIFO.
// Sample-to-valid_o latency 2 cycles; words arriving at a full FIFO are dropped and counted.
module trng_collector
  import trng_pkg::*;
#(
  parameter int CH        = 8,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 16,
  parameter int RC_CUTOFF = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         raw_i,
  input  logic                  raw_vld_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic                  clr_fail_i,
  output logic [OUT_W-1:0]      data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [clog2(DEPTH):0] level_o,
  output logic [15:0]           drop_cnt_o,
  output logic                  health_fail_o
);

  localparam int CW = clog2(OUT_W);
  localparam int RW = clog2(RC_CUTOFF + 1);

  logic             b_r;
  logic             b_vld;
  logic             mode_r;
  logic             prev_bit;
  logic             prev_vld;
  logic [RW-1:0]    rc;
  logic             fail_r;
  logic             pend;
  logic             pend_bit;
  logic [OUT_W-2:0] word;
  logic [CW-1:0]    cnt;
  logic [15:0]      drop_cnt;

  logic             mode_chg;
  logic             same;
  logic [RW-1:0]    rc_nxt;
  logic             hit;
  logic             live;
  logic             emit;
  logic             emit_bit;
  logic [OUT_W-1:0] word_nxt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_r    <= 1'b0;
      b_vld  <= 1'b0;
      mode_r <= MODE_XOR;
    end else begin
      b_vld  <= raw_vld_i & en_i;
      mode_r <= mode_i;
      if (raw_vld_i & en_i) b_r <= ^raw_i;
    end
  end

  always_comb begin
    mode_chg = (mode_i != mode_r);
    same     = prev_vld && (b_r == prev_bit);
    rc_nxt   = same ? rc + RW'(1) : RW'(1);
    // clearing the flag wins over a failure detected in the same cycle
    hit      = b_vld && !fail_r && !clr_fail_i && (rc_nxt == RW'(RC_CUTOFF));
    live     = b_vld && !fail_r && !hit && !mode_chg;
    emit     = 1'b0;
    emit_bit = b_r;
    if (live) begin
      if (mode_r == MODE_XOR) begin
        emit = 1'b1;
      end else if (pend && (pend_bit != b_r)) begin
        emit     = 1'b1;
        emit_bit = pend_bit;
      end
    end
    word_nxt = {word, emit_bit};
    push     = emit && (cnt == CW'(OUT_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_r   <= 1'b0;
      rc       <= '0;
      prev_bit <= 1'b0;
      prev_vld <= 1'b0;
    end else if (clr_fail_i) begin
      fail_r   <= 1'b0;
      rc       <= '0;
      prev_vld <= 1'b0;
    end else if (b_vld && !fail_r) begin
      rc       <= rc_nxt;
      prev_bit <= b_r;
      prev_vld <= 1'b1;
      if (hit) fail_r <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_bit <= 1'b0;
      word     <= '0;
      cnt      <= '0;
    end else if (mode_chg || hit) begin
      pend <= 1'b0;
      word <= '0;
      cnt  <= '0;
    end else if (live) begin
      if (mode_r == MODE_VN) begin
        pend <= ~pend;
        if (!pend) pend_bit <= b_r;
      end
      if (emit) begin
        if (push) begin
          word <= '0;
          cnt  <= '0;
        end else begin
          word <= word_nxt[OUT_W-2:0];
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

  assign pop = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (push && full && !pop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  trng_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (word_nxt),
    .pop      (pop),
    .pop_dat  (data_o),
    .full     (full),
    .empty    (empty),
    .level    (level_o)
  );

  assign valid_o       = ~empty;
  assign drop_cnt_o    = drop_cnt;
  assign health_fail_o = fail_r;

endmodule
